// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder
// Collects K_DEPTH operand vectors into a local tile buffer, then streams the
// tile into the left edge of a systolic array with a one-cycle-per-row skew.
// Fill and stream/drain are not overlapped: the input is stalled while a tile
// is being streamed out.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_vec_valid  : input vector valid
//   i_vec_data   : input vector, lane i at [i*IN_DATA_WIDTH +: IN_DATA_WIDTH]
//   o_vec_ready  : input vector accepted when high together with i_vec_valid
//   o_data_left  : skewed left-edge operand per row (same lane packing)
//   o_spe_en     : per-row PE enable
//   o_mult_clear : per-row accumulator restart, aligned with entry 0
//   o_tile_done  : one-cycle pulse once the last operand has left every lane
module systolic_row_feeder #(
  parameter int unsigned IN_DATA_WIDTH = 4,
  parameter int unsigned N_LANES       = 4,
  parameter int unsigned K_DEPTH       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_vec_valid,
  input  logic [N_LANES*IN_DATA_WIDTH-1:0] i_vec_data,
  output logic                             o_vec_ready,
  output logic [N_LANES*IN_DATA_WIDTH-1:0] o_data_left,
  output logic [N_LANES-1:0]               o_spe_en,
  output logic [N_LANES-1:0]               o_mult_clear,
  output logic                             o_tile_done
);

  localparam int unsigned VW = N_LANES * IN_DATA_WIDTH;
  localparam int unsigned CW = $clog2(K_DEPTH) + 1;
  localparam int unsigned AW = $clog2(K_DEPTH);
  localparam int unsigned DW = $clog2(N_LANES) + 1;
  localparam logic [CW-1:0] LastEntry = CW'(K_DEPTH - 1);
  localparam logic [DW-1:0] LastDrain = DW'(N_LANES - 1);

  typedef enum logic [1:0] {StFill, StStream, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_wr_cnt, w_wr_cnt_d;
  logic [CW-1:0]   r_rd_cnt, w_rd_cnt_d;
  logic [DW-1:0]   r_drain_cnt, w_drain_cnt_d;
  logic            r_done, w_done_d;
  logic [VW-1:0]   r_buf [K_DEPTH];
  logic            w_wr_en;
  logic            w_stream;
  logic            w_first;
  logic [VW-1:0]   w_rd_vec;
  logic [N_LANES-1:0] r_en_pipe;
  logic [N_LANES-1:0] r_clr_pipe;

  assign w_wr_en  = (r_state == StFill) && i_vec_valid;
  assign w_stream = (r_state == StStream);
  assign w_first  = w_stream && (r_rd_cnt == '0);
  // Zero the vector when not streaming so idle lanes carry 0 down the skew.
  assign w_rd_vec = w_stream ? r_buf[r_rd_cnt[AW-1:0]] : '0;

  assign o_vec_ready  = (r_state == StFill);
  assign o_spe_en     = r_en_pipe;
  assign o_mult_clear = r_clr_pipe;
  assign o_tile_done  = r_done;

  // Tile buffer: contents are not reset; the FSM never streams a stale tile.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_cnt[AW-1:0]] <= i_vec_data;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_wr_cnt_d    = r_wr_cnt;
    w_rd_cnt_d    = r_rd_cnt;
    w_drain_cnt_d = r_drain_cnt;
    w_done_d      = 1'b0;
    unique case (r_state)
      StFill: begin
        if (i_vec_valid) begin
          if (r_wr_cnt == LastEntry) begin
            w_wr_cnt_d = '0;
            w_rd_cnt_d = '0;
            w_state_d  = StStream;
          end else begin
            w_wr_cnt_d = r_wr_cnt + 1'b1;
          end
        end
      end
      StStream: begin
        if (r_rd_cnt == LastEntry) begin
          w_rd_cnt_d    = '0;
          w_drain_cnt_d = '0;
          w_state_d     = StDrain;
        end else begin
          w_rd_cnt_d = r_rd_cnt + 1'b1;
        end
      end
      StDrain: begin
        // Wait for the last entry to ripple through the deepest lane.
        if (r_drain_cnt == LastDrain) begin
          w_drain_cnt_d = '0;
          w_done_d      = 1'b1;
          w_state_d     = StFill;
        end else begin
          w_drain_cnt_d = r_drain_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wr_cnt    <= w_wr_cnt_d;
      r_rd_cnt    <= w_rd_cnt_d;
      r_drain_cnt <= w_drain_cnt_d;
      r_done      <= w_done_d;
    end
  end

  // Stage j of the enable/clear chains is the stream strobe delayed j+1 cycles,
  // which is exactly the enable for row j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_pipe  <= '0;
      r_clr_pipe <= '0;
    end else begin
      r_en_pipe[0]  <= w_stream;
      r_clr_pipe[0] <= w_first;
      for (int j = 1; j < N_LANES; j++) begin
        r_en_pipe[j]  <= r_en_pipe[j-1];
        r_clr_pipe[j] <= r_clr_pipe[j-1];
      end
    end
  end

  // Per-lane data skew: lane i has i+1 register stages.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic [IN_DATA_WIDTH-1:0] r_stage [gi+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) begin
          r_stage[j] <= '0;
        end
      end else begin
        r_stage[0] <= w_rd_vec[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        for (int j = 1; j <= gi; j++) begin
          r_stage[j] <= r_stage[j-1];
        end
      end
    end

    assign o_data_left[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = r_stage[gi];
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder (IN_DATA_WIDTH=4, N_LANES=4, K_DEPTH=8).
// Outputs are sampled on the falling edge, inputs are changed there too.
module tb_systolic_row_feeder;

  logic        clk;
  logic        rst_n;
  logic        i_vec_valid;
  logic [15:0] i_vec_data;
  logic        o_vec_ready;
  logic [15:0] o_data_left;
  logic [3:0]  o_spe_en;
  logic [3:0]  o_mult_clear;
  logic        o_tile_done;

  int n_total;
  int n_bad;

  systolic_row_feeder #(
    .IN_DATA_WIDTH (4),
    .N_LANES       (4),
    .K_DEPTH       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vec_valid  (i_vec_valid),
    .i_vec_data   (i_vec_data),
    .o_vec_ready  (o_vec_ready),
    .o_data_left  (o_data_left),
    .o_spe_en     (o_spe_en),
    .o_mult_clear (o_mult_clear),
    .o_tile_done  (o_tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in cycle S+k of a tile built from vec(0..7).
  typedef struct {
    int          k;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [15:0] data;
    logic        done;
    logic        ready;
  } row_t;

  row_t tbl [13];

  function automatic logic [15:0] vec(input int t);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[i*4 +: 4] = 4'((t + i) & 15);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and apply the zeroing rule to every lane.
  task automatic step();
    logic [15:0] d;
    @(negedge clk);
    d = o_data_left;
    for (int i = 0; i < 4; i++) begin
      if (!o_spe_en[i]) begin
        chk($sformatf("zero_lane%0d", i), 32'(d[i*4 +: 4]), 32'd0);
      end
    end
  endtask

  // Offer vec(start..stop-1); optional one-cycle bubble after each. When the
  // tile completes, returns at the falling edge of cycle S.
  task automatic feed(input int start, input int stop, input bit bub);
    for (int t = start; t < stop; t++) begin
      step();
      chk("fill_ready", 32'(o_vec_ready), 32'd1);
      chk("fill_en", 32'(o_spe_en), 32'd0);
      i_vec_valid = 1'b1;
      i_vec_data  = vec(t);
      if (bub && t != stop - 1) begin
        step();
        chk("bubble_ready", 32'(o_vec_ready), 32'd1);
        i_vec_valid = 1'b0;
        i_vec_data  = 16'hEEEE;
      end
    end
    if (stop == 8) begin
      step();
    end else begin
      step();
      i_vec_valid = 1'b0;
    end
  endtask

  // Compare cycles S..S+12 against the table. With bp set, valid stays high:
  // a poison vector is offered until S+12, where vec(0) is offered instead.
  task automatic check_stream(input bit bp);
    for (int r = 0; r < 13; r++) begin
      if (r > 0) step();
      chk($sformatf("k%0d_en", tbl[r].k), 32'(o_spe_en), 32'(tbl[r].en));
      chk($sformatf("k%0d_clr", tbl[r].k), 32'(o_mult_clear), 32'(tbl[r].clr));
      chk($sformatf("k%0d_data", tbl[r].k), 32'(o_data_left), 32'(tbl[r].data));
      chk($sformatf("k%0d_done", tbl[r].k), 32'(o_tile_done), 32'(tbl[r].done));
      chk($sformatf("k%0d_ready", tbl[r].k), 32'(o_vec_ready), 32'(tbl[r].ready));
      if (bp) begin
        i_vec_valid = 1'b1;
        i_vec_data  = (r == 12) ? vec(0) : 16'hEEEE;
      end else begin
        i_vec_valid = 1'b0;
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    // With vec(t) lane i = t+i, every enabled lane shows k-1 in cycle S+k.
    tbl[0]  = '{0,  4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1,  4'b0001, 4'b0001, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{2,  4'b0011, 4'b0010, 16'h0011, 1'b0, 1'b0};
    tbl[3]  = '{3,  4'b0111, 4'b0100, 16'h0222, 1'b0, 1'b0};
    tbl[4]  = '{4,  4'b1111, 4'b1000, 16'h3333, 1'b0, 1'b0};
    tbl[5]  = '{5,  4'b1111, 4'b0000, 16'h4444, 1'b0, 1'b0};
    tbl[6]  = '{6,  4'b1111, 4'b0000, 16'h5555, 1'b0, 1'b0};
    tbl[7]  = '{7,  4'b1111, 4'b0000, 16'h6666, 1'b0, 1'b0};
    tbl[8]  = '{8,  4'b1111, 4'b0000, 16'h7777, 1'b0, 1'b0};
    tbl[9]  = '{9,  4'b1110, 4'b0000, 16'h8880, 1'b0, 1'b0};
    tbl[10] = '{10, 4'b1100, 4'b0000, 16'h9900, 1'b0, 1'b0};
    tbl[11] = '{11, 4'b1000, 4'b0000, 16'hA000, 1'b0, 1'b0};
    tbl[12] = '{12, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b1};

    rst_n       = 1'b0;
    i_vec_valid = 1'b0;
    i_vec_data  = '0;
    step();
    step();
    chk("rst_ready", 32'(o_vec_ready), 32'd1);
    chk("rst_en", 32'(o_spe_en), 32'd0);
    chk("rst_clr", 32'(o_mult_clear), 32'd0);
    chk("rst_data", 32'(o_data_left), 32'd0);
    chk("rst_done", 32'(o_tile_done), 32'd0);
    rst_n = 1'b1;

    // Basic back-to-back tile.
    feed(0, 8, 1'b0);
    check_stream(1'b0);

    // Bubbled fill.
    feed(0, 8, 1'b1);
    check_stream(1'b0);

    // Backpressure across the tile boundary; vec(0) taken at S+12.
    feed(0, 8, 1'b0);
    check_stream(1'b1);
    feed(1, 8, 1'b0);
    check_stream(1'b0);

    // Reset in cycle S+3 of a tile.
    feed(0, 8, 1'b0);
    step();
    step();
    step();
    chk("pre_rst_data", 32'(o_data_left), 32'h0222);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_vec_ready), 32'd1);
    chk("mid_rst_en", 32'(o_spe_en), 32'd0);
    chk("mid_rst_clr", 32'(o_mult_clear), 32'd0);
    chk("mid_rst_data", 32'(o_data_left), 32'd0);
    chk("mid_rst_done", 32'(o_tile_done), 32'd0);
    i_vec_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("post_rst_done", 32'(o_tile_done), 32'd0);
      chk("post_rst_en", 32'(o_spe_en), 32'd0);
    end
    feed(0, 8, 1'b0);
    check_stream(1'b0);

    // Partial fill left idle, then completed.
    feed(0, 5, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("idle_en", 32'(o_spe_en), 32'd0);
      chk("idle_ready", 32'(o_vec_ready), 32'd1);
      chk("idle_done", 32'(o_tile_done), 32'd0);
    end
    feed(5, 8, 1'b0);
    check_stream(1'b0);

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
